// File: rtl/noise_pkg.sv
// Shared defaults and the output-tap helper for the SID-style noise LFSR bank.
package noise_pkg;

    localparam int MAX_LFSR_W = 32;
    localparam int MAX_OUT_W  = 16;

    localparam int                      SID_LFSR_W   = 23;
    localparam logic [SID_LFSR_W-1:0]   SID_SEED     = 23'h37242B;
    localparam int                      SID_TAP_A    = 22;
    localparam int                      SID_TAP_B    = 17;
    localparam int                      SID_OUT_W    = 8;
    localparam logic [SID_OUT_W*5-1:0]  SID_OUT_TAPS = {5'd22, 5'd20, 5'd16, 5'd13,
                                                        5'd11, 5'd7,  5'd4,  5'd2};

    // Entry k of the packed tap list (5 bits each) selects the LFSR bit for sample bit k.
    function automatic logic [MAX_OUT_W-1:0] out_taps(
        input logic [MAX_LFSR_W-1:0]  lfsr,
        input logic [MAX_OUT_W*5-1:0] taps,
        input int                     n_out
    );
        logic [MAX_OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_OUT_W; k++) begin
            if (k < n_out) r[k] = lfsr[taps[k*5 +: 5]];
        end
        return r;
    endfunction

endpackage

// File: rtl/noise_lfsr_ch.sv
// One noise channel: Fibonacci LFSR with step edge detect, seed load, zero-lockup
// recovery and a change strobe.
module noise_lfsr_ch
    import noise_pkg::*;
#(
    parameter int                  LFSR_W   = SID_LFSR_W,
    parameter int                  TAP_A    = SID_TAP_A,
    parameter int                  TAP_B    = SID_TAP_B,
    parameter int                  OUT_W    = SID_OUT_W,
    parameter logic [OUT_W*5-1:0]  OUT_TAPS = SID_OUT_TAPS,
    parameter logic [LFSR_W-1:0]   SEED     = SID_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_i,
    input  logic              free_run_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_seed_i,
    output logic [OUT_W-1:0]  dout_o,
    output logic              stb_o
);

    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic                 step_q;
    logic                 stb_q, stb_d;
    logic                 adv;
    logic [MAX_OUT_W-1:0] tap_bits;
    logic                 unused_tap_bits;

    // Lockup beats load beats advance; an all-zero register must never survive an edge.
    always_comb begin
        adv    = free_run_i | (step_i & ~step_q);
        lfsr_d = lfsr_q;
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (load_i) begin
            lfsr_d = load_seed_i;
        end else if (adv) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};
        end
        stb_d = (lfsr_d != lfsr_q);
    end

    // step_q resets high so a step already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
            step_q <= 1'b1;
            stb_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            step_q <= step_i;
            stb_q  <= stb_d;
        end
    end

    assign tap_bits        = out_taps(MAX_LFSR_W'(lfsr_q), (MAX_OUT_W*5)'(OUT_TAPS), OUT_W);
    assign unused_tap_bits = ^tap_bits;
    assign dout_o          = tap_bits[OUT_W-1:0];
    assign stb_o           = stb_q;

endmodule

// File: rtl/noise_lfsr_bank.sv
// Multi-channel SID-style noise source: CHANNELS independent LFSRs with a shared
// seed-load port.
module noise_lfsr_bank
    import noise_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  LFSR_W   = SID_LFSR_W,
    parameter int                  TAP_A    = SID_TAP_A,
    parameter int                  TAP_B    = SID_TAP_B,
    parameter int                  OUT_W    = SID_OUT_W,
    parameter logic [OUT_W*5-1:0]  OUT_TAPS = SID_OUT_TAPS,
    parameter logic [LFSR_W-1:0]   SEED     = SID_SEED
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [CHANNELS-1:0]                             step,
    input  logic [CHANNELS-1:0]                             free_run,
    input  logic                                            load_valid,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]  load_ch,
    input  logic [LFSR_W-1:0]                               load_seed,
    output logic                                            load_ready,
    output logic [CHANNELS*OUT_W-1:0]                       dout,
    output logic [CHANNELS-1:0]                             dout_stb
);

    localparam int CH_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);

    function automatic bit cfg_ok();
        bit ok;
        ok = (SEED != '0) && (TAP_A < LFSR_W) && (TAP_B < LFSR_W) &&
             (LFSR_W >= 2) && (LFSR_W <= MAX_LFSR_W) && (OUT_W <= MAX_OUT_W) &&
             (CHANNELS >= 1) && (CHANNELS <= 16);
        for (int k = 0; k < OUT_W; k++) begin
            if (int'(OUT_TAPS[k*5 +: 5]) >= LFSR_W) ok = 1'b0;
        end
        return ok;
    endfunction

    if (!cfg_ok()) begin : g_bad_cfg
        $error("noise_lfsr_bank: tap index out of range, bad size, or zero SEED");
    end

    // Load handshake: a seed transfers on any edge where load_valid & load_ready.
    // Ready is low only while in reset; loads to a nonexistent channel are dropped.
    logic ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    assign load_ready = ready_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic hit;
        assign hit = load_valid & ready_q & (load_ch == CH_W'(c));

        noise_lfsr_ch #(
            .LFSR_W   (LFSR_W),
            .TAP_A    (TAP_A),
            .TAP_B    (TAP_B),
            .OUT_W    (OUT_W),
            .OUT_TAPS (OUT_TAPS),
            .SEED     (SEED)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .step_i      (step[c]),
            .free_run_i  (free_run[c]),
            .load_i      (hit),
            .load_seed_i (load_seed),
            .dout_o      (dout[c*OUT_W +: OUT_W]),
            .stb_o       (dout_stb[c])
        );
    end

endmodule

// File: tb/tb_noise_lfsr_bank.sv
// Scoreboard bench for noise_lfsr_bank: directed vectors plus a long random run.
module tb_noise_lfsr_bank;

    localparam logic [22:0] SEED = 23'h37242B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  step = '0;
    logic [3:0]  free_run = '0;
    logic        load_valid = 1'b0;
    logic [1:0]  load_ch = '0;
    logic [22:0] load_seed = '0;
    logic        load_ready;
    logic [31:0] dout;
    logic [3:0]  dout_stb;

    noise_lfsr_bank dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .free_run   (free_run),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_seed  (load_seed),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_stb   (dout_stb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  exp_q[$];
    logic [22:0] m_lfsr[4];
    logic [3:0]  m_stepq;
    logic        m_ready;

    function automatic logic [7:0] taps8(input logic [22:0] v);
        return {v[22], v[20], v[16], v[13], v[11], v[7], v[4], v[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) m_lfsr[c] = SEED;
        m_stepq = 4'hF;
        m_ready = 1'b0;
        exp_q.delete();
    endtask

    // Reference update for one clock edge; pushes the sample expected with each strobe.
    task automatic model_update();
        logic [22:0] nxt;
        logic        adv;
        for (int c = 0; c < 4; c++) begin
            adv = free_run[c] | (step[c] & ~m_stepq[c]);
            nxt = m_lfsr[c];
            if (m_lfsr[c] == 23'd0)                              nxt = SEED;
            else if (load_valid && m_ready && load_ch == 2'(c))  nxt = load_seed;
            else if (adv)                    nxt = {m_lfsr[c][21:0], m_lfsr[c][22] ^ m_lfsr[c][17]};
            if (nxt != m_lfsr[c]) exp_q.push_back({2'(c), taps8(nxt)});
            m_lfsr[c] = nxt;
        end
        m_stepq = step;
        m_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    // Monitor: every strobe pops one expected {channel, sample}; dout tracks the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                check("dout_vs_model", {24'd0, dout[c*8 +: 8]}, {24'd0, taps8(m_lfsr[c])});
                if (dout_stb[c]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL stb_unexpected: got strobe on ch %0d expected none", c);
                    end else begin
                        check("stb_sample", {22'd0, 2'(c), dout[c*8 +: 8]}, {22'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'h70707070);
        check("rst_stb", {28'd0, dout_stb}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        rst = 1'b0;
        check("ready_at_release", {31'd0, load_ready}, 32'd0);
        tick();
        check("ready_after_edge", {31'd0, load_ready}, 32'd1);
        check("idle_dout", dout, 32'h70707070);

        // 2. single step edge on ch0
        step[0] = 1'b1;
        tick();
        check("step0_dout", dout, 32'h7070708B);
        check("step0_stb", {28'd0, dout_stb}, 32'h1);
        step[0] = 1'b0;
        tick();
        check("step0_stb_gone", {28'd0, dout_stb}, 32'h0);

        // 3. held step advances once; free-run advances every edge
        step[1] = 1'b1;
        repeat (10) tick();
        step[1] = 1'b0;
        tick();
        check("held_step_once", {24'd0, dout[15:8]}, 32'h8B);
        free_run[2] = 1'b1;
        repeat (10) tick();
        free_run[2] = 1'b0;
        tick();

        // 4. load zero into ch3, then lockup recovery beats a competing load
        load_valid = 1'b1; load_ch = 2'd3; load_seed = 23'd0;
        tick();
        check("zero_load_dout", {24'd0, dout[31:24]}, 32'h00);
        check("zero_load_stb", {31'd0, dout_stb[3]}, 32'd1);
        load_seed = 23'h123456;
        tick();
        load_valid = 1'b0;
        check("lockup_dout", {24'd0, dout[31:24]}, 32'h70);
        check("lockup_stb", {31'd0, dout_stb[3]}, 32'd1);
        tick();

        // 5. load and step edge on the same cycle: load wins
        step[0] = 1'b1; load_valid = 1'b1; load_ch = 2'd0; load_seed = 23'h000001;
        tick();
        load_valid = 1'b0; step[0] = 1'b0;
        check("load_vs_adv_dout", {24'd0, dout[7:0]}, 32'h00);
        check("load_vs_adv_stb", {31'd0, dout_stb[0]}, 32'd1);
        free_run[0] = 1'b1;
        tick();
        check("adv_to_2", {24'd0, dout[7:0]}, 32'h00);
        tick();
        check("adv_to_4", {24'd0, dout[7:0]}, 32'h01);
        tick();
        tick();
        check("adv_to_16", {24'd0, dout[7:0]}, 32'h02);

        // 6. reset mid free-run, step held high across release
        free_run = 4'hF;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        step = 4'hF;
        model_reset();
        #1;
        check("midrst_dout", dout, 32'h70707070);
        check("midrst_stb", {28'd0, dout_stb}, 32'd0);
        check("midrst_ready", {31'd0, load_ready}, 32'd0);
        free_run = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("release_no_adv", dout, 32'h70707070);
        check("release_no_stb", {28'd0, dout_stb}, 32'd0);

        for (int i = 0; i < 65536; i++) begin
            step       = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) free_run[c] = ($urandom_range(0, 7) == 0);
            load_valid = ($urandom_range(0, 15) == 0);
            load_ch    = 2'($urandom_range(0, 3));
            load_seed  = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
            tick();
        end

        step = '0; free_run = '0; load_valid = 1'b0;
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
